sbit_rate_monitor: RTL and testbench
====================================

Name: sbit_rate_monitor

Overview:
- Downstream consumer of the per-channel S-bit one-shots. Counts one-shot pulses per channel over a programmable gate window.
- At the end of each window, snapshots all counts into a readable bank and raises a one-clock valid strobe.
- Used for per-VFAT S-bit rate monitoring and noisy-channel identification ahead of cluster building. Slow control reads the bank through an address mux.

Parameters:
- NCH, 8: number of one-shot channels monitored.
- CNT_BITS, 16: width of each per-channel counter and snapshot.
- GATE_BITS, 24: width of the gate-length input, in clocks.
- SEL_BITS, 3: width of the read select; must satisfy 2^SEL_BITS >= NCH.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pulse_i  in  NCH  one-shot outputs; each bit is high for 1 clock per hit.
- enable_i  in  1  run gating when high.
- gate_len_i  in  GATE_BITS  window length in clocks; 0 means disabled.
- clear_i  in  1  synchronous clear of counters, snapshots and sequence.
- rd_sel_i  in  SEL_BITS  channel index for readout.
- rd_data_o  out  CNT_BITS  snapshot of the selected channel, registered.
- overflow_o  out  NCH  per-channel saturation flag of the last snapshot.
- snap_valid_o  out  1  1-clock strobe when a new snapshot is loaded.
- snap_seq_o  out  8  snapshot sequence number; wraps 255 -> 0.
- busy_o  out  1  high while in COUNT.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, counters 0, snapshots 0, timer 0, state IDLE.
- States:
  - IDLE: if enable_i && gate_len_i != 0 && !clear_i, load timer <= gate_len_i - 1, clear counters, go to COUNT next cycle. Pulses arriving in IDLE are ignored.
  - COUNT: each cycle, counter[i] <= sat(counter[i] + pulse_i[i]). Decrement the timer while timer != 0.
  - Last cycle of the gate (timer == 0 in COUNT):
    - snapshot[i] <= sat(counter[i] + pulse_i[i]), so the last-cycle pulse is included.
    - overflow_o[i] <= 1 if that value is all-ones.
    - Counters go to 0; the timer reloads from the current gate_len_i - 1. Stay in COUNT, so there is no dead cycle between gates.
    - snap_valid_o goes high on the following cycle for exactly 1 clock, and snap_seq_o increments on that same cycle.
- Gate length: gate_len_i is sampled only at gate start (IDLE exit or reload). Changes mid-gate take effect at the next gate. gate_len_i = 1 gives a snapshot every clock.
- COUNT exit: enable_i low, or gate_len_i == 0 at reload, sends the block to IDLE on the next cycle.
  - An aborted partial gate produces no snapshot, no valid strobe and no sequence increment.
  - Counters are cleared; snapshots keep their previous values.
- Saturation: counters stick at 2^CNT_BITS - 1; there is no wrap.
- clear_i (synchronous, highest priority after reset):
  - Zeroes counters, snapshots, overflow_o, snap_seq_o and the timer; forces IDLE; suppresses snap_valid_o that cycle.
  - If clear_i coincides with a gate's last cycle, clear wins and no snapshot is taken.
- Readout:
  - rd_data_o <= snapshot[rd_sel_i], 1 clock latency; rd_sel_i >= NCH returns 0.
  - When a snapshot load and a read happen in the same cycle, rd_data_o shows the old value. The new value is visible from the next read cycle.
- Reset asserted mid-gate: immediate return to the reset state; no snapshot.
- busy_o = (state == COUNT), registered with the state.

Test Plan:
- Basic count: gate_len=10, enable=1, pulse_i[0] on cycles 1, 3, 5 of the gate, pulse_i[7] every cycle -> snap_valid 1 clock after gate end; ch0 = 3, ch7 = 10; seq = 1; overflow = 0.
- Boundary pulses: gate_len=4, pulse on the first and last gate cycles of ch2, back-to-back gates -> ch2 = 2 each gate; a pulse on the first cycle of gate 2 counts in gate 2, not gate 1; no dead cycle.
- Saturation: CNT_BITS=4, gate_len=20, ch1 pulsing every cycle -> ch1 = 15, overflow_o[1] = 1; next gate with no pulses -> ch1 = 0, overflow_o[1] = 0.
- Abort: gate_len=100, drop enable at cycle 50 -> no snap_valid, seq unchanged, prior snapshot still readable; re-enable -> the full gate of 100 gives the correct count.
- Clear and gate_len change: clear_i on a gate's last cycle -> no valid strobe, all snapshots 0, seq 0. Change gate_len 8->3 mid-gate -> the current gate completes at 8, the next at 3.
- Readout: rd_sel 0..7 then 9 -> rd_data is the matching snapshot 1 clock later, 0 for select 9. Reset mid-gate -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sbit_rate_monitor.sv
// Per-channel S-bit one-shot rate monitor. Counts pulses over a programmable
// gate window and snapshots all channels into a readable bank at window end.

module sbit_rate_lane #(
  parameter int CNT_BITS = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                pulse_i,
  input  logic                cnt_en_i,
  input  logic                snap_ld_i,
  input  logic                snap_clr_i,
  output logic [CNT_BITS-1:0] snap_o,
  output logic                ovf_o
);
  logic [CNT_BITS-1:0] cnt_q, snap_q;
  logic                ovf_q;
  logic [CNT_BITS-1:0] sat;

  // Saturating add: an all-ones counter stays put instead of wrapping.
  assign sat = (&cnt_q) ? cnt_q : cnt_q + CNT_BITS'(pulse_i);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else if (snap_clr_i) begin
      cnt_q  <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (snap_ld_i) begin
        snap_q <= sat;
        ovf_q  <= &sat;
      end
      cnt_q <= cnt_en_i ? sat : '0;
    end
  end

  assign snap_o = snap_q;
  assign ovf_o  = ovf_q;
endmodule

module sbit_rate_monitor #(
  parameter int NCH       = 8,
  parameter int CNT_BITS  = 16,
  parameter int GATE_BITS = 24,
  parameter int SEL_BITS  = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       pulse_i,
  input  logic                 enable_i,
  input  logic [GATE_BITS-1:0] gate_len_i,
  input  logic                 clear_i,
  input  logic [SEL_BITS-1:0]  rd_sel_i,
  output logic [CNT_BITS-1:0]  rd_data_o,
  output logic [NCH-1:0]       overflow_o,
  output logic                 snap_valid_o,
  output logic [7:0]           snap_seq_o,
  output logic                 busy_o
);
  typedef enum logic {IDLE, COUNT} state_t;

  state_t                         state_q, state_d;
  logic [GATE_BITS-1:0]           timer_q, timer_d;
  logic [7:0]                     seq_q;
  logic                           vld_q, busy_q;
  logic [CNT_BITS-1:0]            rd_q, rd_d;
  logic [NCH-1:0][CNT_BITS-1:0]   snap_w;
  logic                           in_gate, last_cyc, snap_ld, cnt_en;

  assign in_gate  = (state_q == COUNT) && enable_i && !clear_i;
  assign last_cyc = in_gate && (timer_q == '0);
  assign snap_ld  = last_cyc;
  // Counters only accumulate mid-gate; on the last cycle the sum goes to the
  // snapshot and the counter restarts from zero for the back-to-back gate.
  assign cnt_en   = in_gate && (timer_q != '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (clear_i) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (state_q == IDLE) begin
      if (enable_i && gate_len_i != '0) begin
        state_d = COUNT;
        timer_d = gate_len_i - GATE_BITS'(1);
      end
    end else if (!enable_i) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (timer_q == '0) begin
      if (gate_len_i != '0) timer_d = gate_len_i - GATE_BITS'(1);
      else                  state_d = IDLE;
    end else begin
      timer_d = timer_q - GATE_BITS'(1);
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NCH; i++)
      if (rd_sel_i == SEL_BITS'(i)) rd_d = snap_w[i];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      seq_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      busy_q  <= (state_d == COUNT);
      vld_q   <= snap_ld;
      rd_q    <= rd_d;
      if (clear_i)      seq_q <= '0;
      else if (snap_ld) seq_q <= seq_q + 8'd1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    sbit_rate_lane #(.CNT_BITS(CNT_BITS)) u_lane (
      .clock      (clock),
      .reset_n    (reset_n),
      .pulse_i    (pulse_i[g]),
      .cnt_en_i   (cnt_en),
      .snap_ld_i  (snap_ld),
      .snap_clr_i (clear_i),
      .snap_o     (snap_w[g]),
      .ovf_o      (overflow_o[g])
    );
  end

  assign rd_data_o    = rd_q;
  assign snap_valid_o = vld_q;
  assign snap_seq_o   = seq_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_sbit_rate_monitor.sv
// Directed bench for sbit_rate_monitor: narrow counters to reach saturation
// and a wide select to reach out-of-range readout.
module tb_sbit_rate_monitor;
  localparam int NCH = 8, CNT_BITS = 4, GATE_BITS = 24, SEL_BITS = 4;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NCH-1:0]       pulse_i = '0;
  logic                 enable_i = 1'b0;
  logic [GATE_BITS-1:0] gate_len_i = '0;
  logic                 clear_i = 1'b0;
  logic [SEL_BITS-1:0]  rd_sel_i = '0;
  logic [CNT_BITS-1:0]  rd_data_o;
  logic [NCH-1:0]       overflow_o;
  logic                 snap_valid_o;
  logic [7:0]           snap_seq_o;
  logic                 busy_o;

  int total = 0, passed = 0, stb;

  sbit_rate_monitor #(.NCH(NCH), .CNT_BITS(CNT_BITS), .GATE_BITS(GATE_BITS),
                      .SEL_BITS(SEL_BITS)) dut (
    .clock(clock), .reset_n(reset_n), .pulse_i(pulse_i), .enable_i(enable_i),
    .gate_len_i(gate_len_i), .clear_i(clear_i), .rd_sel_i(rd_sel_i),
    .rd_data_o(rd_data_o), .overflow_o(overflow_o), .snap_valid_o(snap_valid_o),
    .snap_seq_o(snap_seq_o), .busy_o(busy_o));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  initial begin
    #3;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_seq", 32'(snap_seq_o), 0);
    chk("rst_vld", 32'(snap_valid_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    chk("rst_rd", 32'(rd_data_o), 0);
    step();
    reset_n = 1'b1;
    step();

    // Basic count: gate 10, ch0 on cycles 1,3,5, ch7 every cycle
    gate_len_i = 10; enable_i = 1'b1;
    step();
    chk("basic_busy", 32'(busy_o), 1);
    stb = 0;
    for (int k = 0; k < 10; k++) begin
      pulse_i = 8'h80 | ((k == 1 || k == 3 || k == 5) ? 8'h01 : 8'h00);
      step();
      if (k < 9 && snap_valid_o) stb++;
    end
    chk("basic_early_stb", 32'(stb), 0);
    chk("basic_vld", 32'(snap_valid_o), 1);
    chk("basic_seq", 32'(snap_seq_o), 1);
    chk("basic_ovf", 32'(overflow_o), 0);
    pulse_i = '0; rd_sel_i = 0;
    step();
    chk("basic_ch0", 32'(rd_data_o), 3);
    chk("basic_vld_1clk", 32'(snap_valid_o), 0);
    rd_sel_i = 7;
    step();
    chk("basic_ch7", 32'(rd_data_o), 10);

    // Clear, then back-to-back gates of 4 with ch2 on first/last cycles
    clear_i = 1'b1;
    step();
    chk("clr_seq", 32'(snap_seq_o), 0);
    chk("clr_busy", 32'(busy_o), 0);
    clear_i = 1'b0; gate_len_i = 4; rd_sel_i = 2;
    step();
    for (int g = 1; g <= 3; g++) begin
      for (int k = 0; k < 4; k++) begin
        pulse_i = (k == 0 || k == 3 || (g == 3 && k == 1)) ? 8'h04 : 8'h00;
        step();
        if (g > 1 && k == 0) begin
          chk("bnd_ch2", 32'(rd_data_o), 2);
          chk("bnd_vld_off", 32'(snap_valid_o), 0);
        end
        if (g == 3 && k == 3) chk("bnd_old_on_load", 32'(rd_data_o), 2);
      end
      chk("bnd_vld", 32'(snap_valid_o), 1);
      chk("bnd_seq", 32'(snap_seq_o), 32'(g));
    end
    pulse_i = '0;
    step();
    chk("bnd_ch2_g3", 32'(rd_data_o), 3);
    enable_i = 1'b0;
    step();
    chk("bnd_idle", 32'(busy_o), 0);

    // Saturation: gate 20, ch1 every cycle; next gate ch1 idle, ch5 x7
    gate_len_i = 20; enable_i = 1'b1; pulse_i = 8'h02;
    step();
    for (int k = 0; k < 20; k++) step();
    chk("sat_vld", 32'(snap_valid_o), 1);
    chk("sat_seq", 32'(snap_seq_o), 4);
    chk("sat_ovf", 32'(overflow_o), 32'h02);
    rd_sel_i = 1;
    for (int k = 0; k < 20; k++) begin
      pulse_i = (k < 7) ? 8'h20 : 8'h00;
      step();
      if (k == 0) chk("sat_ch1", 32'(rd_data_o), 15);
    end
    chk("sat2_seq", 32'(snap_seq_o), 5);
    chk("sat2_ovf", 32'(overflow_o), 0);
    step();
    chk("sat2_ch1", 32'(rd_data_o), 0);
    enable_i = 1'b0;
    step();

    // Abort gate 100 at cycle 50, then a full gate: ch3 every 10th cycle
    gate_len_i = 100; enable_i = 1'b1;
    step();
    stb = 0;
    for (int k = 0; k < 50; k++) begin
      pulse_i = (k % 10 == 0) ? 8'h08 : 8'h00;
      step();
      if (snap_valid_o) stb++;
    end
    enable_i = 1'b0; pulse_i = '0;
    step();
    chk("abort_stb", 32'(stb + int'(snap_valid_o)), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_seq", 32'(snap_seq_o), 5);
    rd_sel_i = 5;
    step();
    chk("abort_prior_ch5", 32'(rd_data_o), 7);
    enable_i = 1'b1;
    step();
    stb = 0;
    for (int k = 0; k < 100; k++) begin
      pulse_i = (k % 10 == 0) ? 8'h08 : 8'h00;
      step();
      if (k < 99 && snap_valid_o) stb++;
    end
    chk("full_early_stb", 32'(stb), 0);
    chk("full_seq", 32'(snap_seq_o), 6);
    pulse_i = '0; rd_sel_i = 3;
    step();
    chk("full_ch3", 32'(rd_data_o), 10);
    rd_sel_i = 5;
    step();
    chk("full_ch5", 32'(rd_data_o), 0);
    enable_i = 1'b0;
    step();

    // Clear on last gate cycle, then gate_len 8 -> 3 mid-gate
    gate_len_i = 8; enable_i = 1'b1;
    step();
    for (int k = 0; k < 7; k++) step();
    clear_i = 1'b1;
    step();
    chk("lastclr_vld", 32'(snap_valid_o), 0);
    chk("lastclr_seq", 32'(snap_seq_o), 0);
    chk("lastclr_busy", 32'(busy_o), 0);
    clear_i = 1'b0; rd_sel_i = 3;
    step();
    chk("lastclr_ch3", 32'(rd_data_o), 0);
    pulse_i = 8'h10;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) gate_len_i = 3;
      step();
      if (k == 6) chk("glen_still8", 32'(snap_valid_o), 0);
    end
    chk("glen8_vld", 32'(snap_valid_o), 1);
    chk("glen8_seq", 32'(snap_seq_o), 1);
    rd_sel_i = 4;
    step();
    chk("glen8_ch4", 32'(rd_data_o), 8);
    step();
    step();
    chk("glen3_vld", 32'(snap_valid_o), 1);
    chk("glen3_seq", 32'(snap_seq_o), 2);
    step();
    chk("glen3_ch4", 32'(rd_data_o), 3);
    enable_i = 1'b0; pulse_i = '0;
    step();

    // Readout sweep: channel i gets i pulses
    gate_len_i = 8; enable_i = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NCH; i++) pulse_i[i] = (k < i);
      step();
    end
    chk("sweep_seq", 32'(snap_seq_o), 3);
    pulse_i = '0;
    for (int j = 0; j <= 9; j++) begin
      if (j == 8) continue;
      rd_sel_i = SEL_BITS'(j);
      step();
      chk($sformatf("sweep_rd%0d", j), 32'(rd_data_o), (j < 8) ? 32'(j) : 0);
    end

    // Asynchronous reset mid-gate
    chk("pre_rst_busy", 32'(busy_o), 1);
    chk("pre_rst_seq", 32'(snap_seq_o), 4);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_seq", 32'(snap_seq_o), 0);
    chk("arst_vld", 32'(snap_valid_o), 0);
    chk("arst_ovf", 32'(overflow_o), 0);
    chk("arst_rd", 32'(rd_data_o), 0);
    reset_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
